sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/slc3_mem_pkg.sv | 29 ++
 rtl/sram_responder_if.sv | 27 ++
 rtl/sram_array.sv | 36 +++
 rtl/tristate.sv | 15 +
 rtl/sram_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM responder.
// Holds the FSM state enum, default build parameters, bus widths,
// the byte-fill constant for masked lanes, and an address-range helper.
package slc3_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_W      = 8;
    localparam int unsigned DEFAULT_WAIT_STATES = 2;
    localparam int unsigned ADDR_BITS           = 20;
    localparam int unsigned DATA_W              = 16;
    localparam int unsigned CNT_W               = 4;

    // Value returned on a byte lane whose strobe is deasserted
    localparam logic [7:0] BYTE_FILL = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        WRITE,
        WRITE_HOLD
    } state_t;

    // True when the address has set bits above the implemented depth
    function automatic logic addr_out_of_range(input logic [ADDR_BITS-1:0] addr,
                                               input int unsigned          addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Strobe/address/status bundle between the SLC-3 memory interface and the
// SRAM responder.
//   master: drives CE, OE, WE, UB, LB (active-low) and ADDR; sees Ready, Busy
//   slave : the responder; drives Ready and Busy
interface sram_responder_if;
    import slc3_mem_pkg::*;

    logic                 CE;
    logic                 OE;
    logic                 WE;
    logic                 UB;
    logic                 LB;
    logic [ADDR_BITS-1:0] ADDR;
    logic                 Ready;
    logic                 Busy;

    modport master (
        output CE, OE, WE, UB, LB, ADDR,
        input  Ready, Busy
    );

    modport slave (
        input  CE, OE, WE, UB, LB, ADDR,
        output Ready, Busy
    );

endinterface

// File: rtl/sram_array.sv
// Word-organised storage: synchronous write with per-byte enables and a
// registered read port. Contents are never reset.
//   clk               : clock
//   wr_en, wr_be      : write strobe, byte enables {upper, lower}
//   wr_addr, wr_data  : write address / data
//   rd_en, rd_addr    : read strobe / address
//   rd_data           : registered read data, updated only when rd_en is high
module sram_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [1:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [15:0] mem [DEPTH];

    // Byte-lane write
    always_ff @(posedge clk) begin
        if (wr_en && wr_be[1]) mem[wr_addr][15:8] <= wr_data[15:8];
        if (wr_en && wr_be[0]) mem[wr_addr][7:0]  <= wr_data[7:0];
    end

    // Registered read
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tristate.sv
// Tristate pad driver: drives pad with d while oe is high, high-Z otherwise.
//   oe  : output enable
//   d   : value to drive
//   pad : shared bidirectional net
module tristate #(
    parameter int unsigned W = 16
) (
    input  logic         oe,
    input  logic [W-1:0] d,
    inout  wire  [W-1:0] pad
);

    assign pad = oe ? d : {W{1'bz}};

endmodule

// File: rtl/sram_responder.sv
// SRAM responder for the SLC-3 memory interface: answers active-low
// CE/OE/WE/UB/LB strobes with a programmable read latency and one-shot
// byte-lane writes into an internal array.
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous, active-low
//   bus   : strobes and ADDR in; Ready (valid read data) and Busy (not IDLE) out
//   Data  : shared 16-bit bus, driven only in READ_DRIVE
module sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_responder_if.slave   bus,
    inout  wire  [DATA_W-1:0] Data
);

    localparam logic           NO_WAIT   = (WAIT_STATES == 0);
    localparam int unsigned    WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_LOAD);

    state_t               state;
    logic [CNT_W-1:0]     cnt;

    logic [ADDR_BITS-1:0] lat_addr;
    logic [DATA_W-1:0]    lat_data;
    logic                 lat_ub;
    logic                 lat_lb;

    logic                 rd_ub;
    logic                 rd_lb;
    logic                 rd_oob;
    logic [DATA_W-1:0]    rd_raw;

    logic                 rd_req_c;
    logic                 wr_req_c;
    logic                 rd_fire_c;
    logic [ADDR_BITS-1:0] rd_addr_c;
    logic                 wr_en_c;
    logic                 drive_en_c;
    logic [DATA_W-1:0]    drive_c;

    assign rd_req_c = !bus.CE && !bus.OE && bus.WE;
    assign wr_req_c = !bus.CE && !bus.WE;

    // Array read is launched on the edge that enters READ_DRIVE
    always_comb begin
        rd_fire_c = 1'b0;
        rd_addr_c = bus.ADDR;
        if (Reset) begin
            case (state)
                IDLE:       rd_fire_c = NO_WAIT && rd_req_c;
                READ_WAIT: begin
                    rd_addr_c = lat_addr;
                    rd_fire_c = (cnt == '0);
                end
                READ_DRIVE: rd_fire_c = NO_WAIT && rd_req_c && (bus.ADDR != lat_addr);
                default:    rd_fire_c = 1'b0;
            endcase
        end
    end

    // A write coincident with reset, or aimed above the array, is dropped
    assign wr_en_c = Reset && (state == WRITE) && !addr_out_of_range(lat_addr, ADDR_W);

    // Control FSM with registered Ready/Busy
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.Ready <= 1'b0;
            bus.Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req_c) begin
                        state    <= WRITE;
                        bus.Busy <= 1'b1;
                    end else if (rd_req_c) begin
                        bus.Busy <= 1'b1;
                        if (NO_WAIT) begin
                            state     <= READ_DRIVE;
                            bus.Ready <= 1'b1;
                        end else begin
                            state <= READ_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                READ_WAIT: begin
                    if (cnt == '0) begin
                        state     <= READ_DRIVE;
                        bus.Ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                READ_DRIVE: begin
                    if (!rd_req_c) begin
                        state     <= IDLE;
                        bus.Ready <= 1'b0;
                        bus.Busy  <= 1'b0;
                    end else if (bus.ADDR != lat_addr && !NO_WAIT) begin
                        state     <= READ_WAIT;
                        cnt       <= CNT_LOAD;
                        bus.Ready <= 1'b0;
                    end
                end
                WRITE: begin
                    state <= WRITE_HOLD;
                end
                WRITE_HOLD: begin
                    if (!wr_req_c) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.Ready <= 1'b0;
                    bus.Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Request capture: address/data/lanes for writes, address for reads
    always_ff @(posedge Clk) begin
        if (Reset && state == IDLE && wr_req_c) begin
            lat_addr <= bus.ADDR;
            lat_data <= Data;
            lat_ub   <= bus.UB;
            lat_lb   <= bus.LB;
        end else if (Reset && (state == IDLE || state == READ_DRIVE) && rd_req_c) begin
            lat_addr <= bus.ADDR;
        end
    end

    // Lane masks and range flag travel with the read data
    always_ff @(posedge Clk) begin
        if (rd_fire_c) begin
            rd_ub  <= bus.UB;
            rd_lb  <= bus.LB;
            rd_oob <= addr_out_of_range(rd_addr_c, ADDR_W);
        end
    end

    sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (Clk),
        .wr_en   (wr_en_c),
        .wr_be   ({~lat_ub, ~lat_lb}),
        .wr_addr (lat_addr[ADDR_W-1:0]),
        .wr_data (lat_data),
        .rd_en   (rd_fire_c),
        .rd_addr (rd_addr_c[ADDR_W-1:0]),
        .rd_data (rd_raw)
    );

    always_comb begin
        drive_c = '0;
        if (!rd_oob) begin
            drive_c[15:8] = rd_ub ? BYTE_FILL : rd_raw[15:8];
            drive_c[7:0]  = rd_lb ? BYTE_FILL : rd_raw[7:0];
        end
    end

    assign drive_en_c = (state == READ_DRIVE);

    tristate #(
        .W (DATA_W)
    ) u_drv (
        .oe  (drive_en_c),
        .d   (drive_c),
        .pad (Data)
    );

endmodule
